// File: rtl/merge_crossbar_lane_pkg.sv
// merge_pkg: shared widths, merged-word struct and framing state for the merge crossbar lane
package merge_pkg;
  localparam int PNUM_W = 4;
  localparam int ZNUM_W = 12;
  localparam int SEG_W = 32;
  typedef struct packed {
    logic sop;
    logic eop;
    logic [ZNUM_W-1:0] zero_num;
    logic [PNUM_W-1:0] pkt_num;
    logic [SEG_W-1:0] dout;
  } merge_word_t;
  typedef enum logic {IDLE, IN_PKT} frame_state_t;
endpackage

// File: rtl/merge_crossbar_lane_fifo.sv
// merge_sync_fifo: sync FIFO (clk, rst_n, wr_en/din, rd_en/dout head, count/empty/full)
module merge_sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [W-1:0]               din,
  input  logic                       rd_en,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + (AW+1)'(1);
      if (rd_en) rptr <= rptr + (AW+1)'(1);
    end
    if (wr_en) mem[wptr[AW-1:0]] <= din;
  end
  assign count = wptr - rptr;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign dout = mem[rptr[AW-1:0]];
endmodule

// File: rtl/merge_crossbar_lane.sv
// merge_crossbar_lane: lane-ID segment select + XOR/OR merge, FIFO backpressure, framing errors, stats
module merge_crossbar_lane
  import merge_pkg::*;
#(
  parameter int SEG_NUM_IN = 8,
  parameter int SEG_W = 32,
  parameter int ZNUM_W = 12,
  parameter int PNUM_W = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [PNUM_W-1:0]            cfg_pkt_num,
  input  logic                         cfg_load,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [SEG_NUM_IN-1:0]        in_sop,
  input  logic [SEG_NUM_IN-1:0]        in_eop,
  input  logic [SEG_NUM_IN-1:0]        in_dval,
  input  logic [PNUM_W*SEG_NUM_IN-1:0] in_packet_num,
  input  logic [ZNUM_W*SEG_NUM_IN-1:0] in_zero_num,
  input  logic [SEG_W*SEG_NUM_IN-1:0]  in_dout,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_sop,
  output logic                         out_eop,
  output logic [PNUM_W-1:0]            out_packet_num,
  output logic [ZNUM_W-1:0]            out_zero_num,
  output logic [SEG_W-1:0]             out_dout,
  output logic                         err_sop_in_pkt,
  output logic                         err_eop_no_pkt,
  output logic                         err_multi_eop,
  input  logic                         err_clr,
  output logic [CNT_W-1:0]             stat_words,
  output logic [CNT_W-1:0]             stat_pkts
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = $clog2(SEG_NUM_IN+1);
  logic [PNUM_W-1:0] lane_id, s1_pn;
  logic [SEG_NUM_IN-1:0] match, s1_sop, s1_eop, s1_dval;
  logic [ZNUM_W*SEG_NUM_IN-1:0] m_zn, s1_zn;
  logic [SEG_W*SEG_NUM_IN-1:0] m_dout, s1_dout;
  logic s1_valid, s2_valid, accept, rd_en, empty, full;
  logic [EW-1:0] r_eop_cnt, s2_eop_cnt;
  logic [ZNUM_W-1:0] r_zn;
  logic [SEG_W-1:0] r_dout;
  logic [AW:0] count;
  logic [AW+1:0] occ;
  logic set_sop, set_eop, set_multi;
  merge_word_t s2_word, head;
  frame_state_t state, state_nx;
  always_comb begin
    match = '0;
    m_zn = '0;
    m_dout = '0;
    for (int j = 0; j < SEG_NUM_IN; j++) begin
      match[j] = in_packet_num[PNUM_W*j +: PNUM_W] == lane_id;
      m_zn[ZNUM_W*j +: ZNUM_W] = match[j] ? in_zero_num[ZNUM_W*j +: ZNUM_W] : '0;
      m_dout[SEG_W*j +: SEG_W] = match[j] ? in_dout[SEG_W*j +: SEG_W] : '0;
    end
  end
  always_comb begin
    r_dout = '0;
    r_zn = '0;
    r_eop_cnt = '0;
    for (int j = 0; j < SEG_NUM_IN; j++) begin
      r_dout = r_dout ^ s1_dout[SEG_W*j +: SEG_W];
      r_zn = r_zn | s1_zn[ZNUM_W*j +: ZNUM_W];
      r_eop_cnt = r_eop_cnt + EW'(s1_eop[j]);
    end
  end
  // s1/s2 are counted as FIFO occupancy so the pipeline never has to stall
  assign occ = (AW+2)'(count) + (AW+2)'(s1_valid) + (AW+2)'(s2_valid);
  assign in_ready = rst_n & !full & (occ <= (AW+2)'(FIFO_DEPTH-1));
  assign accept = in_valid & in_ready;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane_id <= '0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (cfg_load) lane_id <= cfg_pkt_num;
      s1_valid <= accept;
      s2_valid <= s1_valid & |s1_dval;
    end
    if (accept) begin
      s1_pn <= lane_id;
      s1_sop <= in_sop & match;
      s1_eop <= in_eop & match;
      s1_dval <= in_dval & match;
      s1_zn <= m_zn;
      s1_dout <= m_dout;
    end
    if (s1_valid) begin
      s2_word <= '{sop: |s1_sop, eop: |s1_eop, zero_num: r_zn, pkt_num: s1_pn, dout: r_dout};
      s2_eop_cnt <= r_eop_cnt;
    end
  end
  merge_sync_fifo #(.W($bits(merge_word_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(s2_valid),
    .din(s2_word),
    .rd_en(rd_en),
    .dout(head),
    .count(count),
    .empty(empty),
    .full(full)
  );
  assign out_valid = rst_n & !empty;
  assign rd_en = out_valid & out_ready;
  assign out_sop = head.sop;
  assign out_eop = head.eop;
  assign out_packet_num = head.pkt_num;
  assign out_zero_num = head.zero_num;
  assign out_dout = head.dout;
  always_comb begin
    state_nx = state;
    set_sop = 1'b0;
    set_eop = 1'b0;
    set_multi = 1'b0;
    if (s2_valid) begin
      set_multi = s2_eop_cnt > EW'(1);
      set_sop = state == IN_PKT && s2_word.sop && !s2_word.eop;
      set_eop = state == IDLE && s2_word.eop && !s2_word.sop;
      state_nx = state == IDLE ? (s2_word.sop && !s2_word.eop ? IN_PKT : IDLE)
                               : (s2_word.eop ? IDLE : IN_PKT);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      err_sop_in_pkt <= 1'b0;
      err_eop_no_pkt <= 1'b0;
      err_multi_eop <= 1'b0;
      stat_words <= '0;
      stat_pkts <= '0;
    end else begin
      state <= state_nx;
      err_sop_in_pkt <= set_sop | (err_sop_in_pkt & !err_clr);
      err_eop_no_pkt <= set_eop | (err_eop_no_pkt & !err_clr);
      err_multi_eop <= set_multi | (err_multi_eop & !err_clr);
      if (s2_valid && !(&stat_words)) stat_words <= stat_words + CNT_W'(1);
      if (s2_valid && s2_word.eop && !(&stat_pkts)) stat_pkts <= stat_pkts + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_merge_crossbar_lane.sv
// tb_merge_crossbar_lane: scoreboard bench with directed merge, backpressure, framing, cfg and reset vectors
module tb_merge_crossbar_lane;
  typedef struct packed {
    logic sop;
    logic eop;
    logic [11:0] zn;
    logic [3:0] pn;
    logic [31:0] dout;
  } exp_t;
  logic clk = 0;
  logic rst_n = 0;
  logic [3:0] cfg_pkt_num = '0;
  logic cfg_load = 0;
  logic in_valid = 0;
  logic in_ready;
  logic [7:0] in_sop = '0, in_eop = '0, in_dval = '0;
  logic [31:0] in_packet_num = '1;
  logic [95:0] in_zero_num = '0;
  logic [255:0] in_dout = '0;
  logic out_valid, out_ready = 1;
  logic out_sop, out_eop;
  logic [3:0] out_packet_num;
  logic [11:0] out_zero_num;
  logic [31:0] out_dout;
  logic err_sop_in_pkt, err_eop_no_pkt, err_multi_eop;
  logic err_clr = 0;
  logic [15:0] stat_words, stat_pkts;
  int checks = 0, failures = 0;
  exp_t sb[$];
  exp_t mon_got, mon_exp;
  merge_crossbar_lane dut (
    .clk(clk), .rst_n(rst_n), .cfg_pkt_num(cfg_pkt_num), .cfg_load(cfg_load),
    .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop), .in_eop(in_eop),
    .in_dval(in_dval), .in_packet_num(in_packet_num), .in_zero_num(in_zero_num),
    .in_dout(in_dout), .out_valid(out_valid), .out_ready(out_ready),
    .out_sop(out_sop), .out_eop(out_eop), .out_packet_num(out_packet_num),
    .out_zero_num(out_zero_num), .out_dout(out_dout),
    .err_sop_in_pkt(err_sop_in_pkt), .err_eop_no_pkt(err_eop_no_pkt),
    .err_multi_eop(err_multi_eop), .err_clr(err_clr),
    .stat_words(stat_words), .stat_pkts(stat_pkts)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endtask
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      mon_got = '{sop: out_sop, eop: out_eop, zn: out_zero_num, pn: out_packet_num, dout: out_dout};
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word actual=%h required=none", mon_got);
      end else begin
        mon_exp = sb.pop_front();
        chk("word", 64'(mon_got), 64'(mon_exp));
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic clr_bus;
    in_sop = '0;
    in_eop = '0;
    in_dval = '0;
    in_zero_num = '0;
    in_dout = '0;
    in_packet_num = '1;
  endtask
  task automatic seg(input int j, input logic [3:0] pn, input logic s, input logic e,
                     input logic [11:0] zn, input logic [31:0] dv);
    in_packet_num[4*j +: 4] = pn;
    in_sop[j] = s;
    in_eop[j] = e;
    in_dval[j] = 1'b1;
    in_zero_num[12*j +: 12] = zn;
    in_dout[32*j +: 32] = dv;
  endtask
  task automatic send(input logic want, input exp_t e);
    logic ok;
    ok = 0;
    if (want) sb.push_back(e);
    in_valid = 1;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      if (!ok) tick(1);
    end
    if (!ok) chk("send_timeout", 64'(in_ready), 64'(1));
    else tick(1);
    in_valid = 0;
    clr_bus();
  endtask
  task automatic drain;
    for (int k = 0; k < 100 && sb.size() != 0; k++) tick(1);
    chk("drain_empty", 64'(sb.size()), 64'(0));
  endtask
  function automatic exp_t w(input logic s, input logic e, input logic [11:0] zn,
                             input logic [3:0] pn, input logic [31:0] dv);
    return '{sop: s, eop: e, zn: zn, pn: pn, dout: dv};
  endfunction
  initial begin
    int lat, acc;
    logic took;
    tick(2);
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    rst_n = 1;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));
    chk("post_rst_stats", 64'({stat_words, stat_pkts}), 64'(0));
    chk("post_rst_errs", 64'({err_sop_in_pkt, err_eop_no_pkt, err_multi_eop}), 64'(0));
    cfg_pkt_num = 4'd3;
    cfg_load = 1;
    tick(1);
    cfg_load = 0;
    // merge: segs 0-2 match lane 3, segs 3-7 belong to lane 5
    seg(0, 3, 0, 0, 0, 32'h1);
    seg(1, 3, 0, 0, 0, 32'h2);
    seg(2, 3, 0, 0, 0, 32'h4);
    for (int j = 3; j < 8; j++) seg(j, 5, 1, 1, 12'hFFF, 32'hF0F0_0000 + j);
    send(1, w(0, 0, 0, 3, 32'h7));
    lat = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) break;
      tick(1);
      lat++;
    end
    chk("latency", 64'(lat), 64'(3));
    tick(2);
    chk("stat_words_1", 64'(stat_words), 64'(1));
    // sop beat then eop beat with zero_num
    seg(1, 3, 1, 0, 0, 32'hA5);
    send(1, w(1, 0, 0, 3, 32'hA5));
    seg(4, 3, 0, 1, 12'h00A, 32'h5A);
    send(1, w(0, 1, 12'h00A, 3, 32'h5A));
    tick(4);
    chk("stat_pkts_1", 64'(stat_pkts), 64'(1));
    chk("stat_words_3", 64'(stat_words), 64'(3));
    chk("errs_clean", 64'({err_sop_in_pkt, err_eop_no_pkt, err_multi_eop}), 64'(0));
    // backpressure: continuous in_valid with out_ready low
    out_ready = 0;
    acc = 0;
    seg(0, 3, 1, 1, 0, 32'h100);
    in_valid = 1;
    repeat (12) begin
      @(negedge clk);
      took = in_ready;
      if (took) sb.push_back(w(1, 1, 0, 3, 32'h100 + acc));
      tick(1);
      if (took) begin
        acc++;
        in_dout[31:0] = 32'h100 + acc;
      end
    end
    in_valid = 0;
    clr_bus();
    tick(3);
    chk("stall_accepted", 64'(acc), 64'(4));
    chk("stall_out_valid", 64'(out_valid), 64'(1));
    chk("stall_head_hold", 64'(out_dout), 64'(32'h100));
    chk("stat_words_7", 64'(stat_words), 64'(7));
    out_ready = 1;
    drain();
    chk("stat_pkts_5", 64'(stat_pkts), 64'(5));
    // framing: sop, sop, eop then multi-eop beat
    seg(0, 3, 1, 0, 0, 32'h11);
    send(1, w(1, 0, 0, 3, 32'h11));
    seg(0, 3, 1, 0, 0, 32'h12);
    send(1, w(1, 0, 0, 3, 32'h12));
    seg(0, 3, 0, 1, 0, 32'h13);
    send(1, w(0, 1, 0, 3, 32'h13));
    tick(4);
    chk("err_sop_in_pkt", 64'({err_sop_in_pkt, err_eop_no_pkt, err_multi_eop}), 64'(3'b100));
    seg(2, 3, 1, 1, 0, 32'h10);
    seg(5, 3, 0, 1, 0, 32'h20);
    send(1, w(1, 1, 0, 3, 32'h30));
    tick(4);
    chk("err_multi_eop", 64'({err_sop_in_pkt, err_eop_no_pkt, err_multi_eop}), 64'(3'b101));
    chk("stat_pkts_7", 64'(stat_pkts), 64'(7));
    err_clr = 1;
    tick(1);
    err_clr = 0;
    chk("err_clr", 64'({err_sop_in_pkt, err_eop_no_pkt, err_multi_eop}), 64'(0));
    drain();
    // lane_id change 3->5 with two beats in flight
    seg(0, 3, 0, 0, 0, 32'h3);
    seg(1, 5, 0, 0, 0, 32'h5);
    send(1, w(0, 0, 0, 3, 32'h3));
    seg(0, 3, 0, 0, 0, 32'h3);
    seg(1, 5, 0, 0, 0, 32'h5);
    send(1, w(0, 0, 0, 3, 32'h3));
    cfg_pkt_num = 4'd5;
    cfg_load = 1;
    tick(1);
    cfg_load = 0;
    seg(0, 3, 0, 0, 0, 32'h3);
    seg(1, 5, 0, 0, 0, 32'h5);
    send(1, w(0, 0, 0, 5, 32'h5));
    drain();
    // reset mid-packet with 3 words queued
    out_ready = 0;
    seg(1, 5, 1, 0, 0, 32'hB1);
    send(0, w(0, 0, 0, 0, 0));
    seg(1, 5, 0, 0, 0, 32'hB2);
    send(0, w(0, 0, 0, 0, 0));
    seg(1, 5, 0, 0, 0, 32'hB3);
    send(0, w(0, 0, 0, 0, 0));
    tick(4);
    chk("pre_rst_out_valid", 64'(out_valid), 64'(1));
    rst_n = 0;
    tick(1);
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_in_ready", 64'(in_ready), 64'(0));
    chk("mid_rst_stats", 64'({stat_words, stat_pkts}), 64'(0));
    rst_n = 1;
    #1;
    chk("after_rst_in_ready", 64'(in_ready), 64'(1));
    chk("after_rst_out_valid", 64'(out_valid), 64'(0));
    out_ready = 1;
    seg(3, 0, 0, 1, 0, 32'h77);
    send(1, w(0, 1, 0, 0, 32'h77));
    tick(4);
    chk("err_eop_no_pkt", 64'({err_sop_in_pkt, err_eop_no_pkt, err_multi_eop}), 64'(3'b010));
    chk("after_rst_stats", 64'({stat_words, stat_pkts}), 64'({16'd1, 16'd1}));
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
